// File: rtl/sdram_ring_fifo.sv
// Streaming sample FIFO that uses SDRAM as a large circular buffer; returned
// read data lands in a small credit-protected on-chip output buffer.
module sdram_ring_fifo #(
   parameter int unsigned buffer_aw = 24,
   parameter int unsigned out_depth = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [15:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        avalid,
   output logic        awe,
   output logic [23:0] aaddr,
   output logic [15:0] adata,
   input  logic        aready,
   input  logic [15:0] bdata,
   input  logic        bvalid,
   output logic [24:0] level,
   output logic        empty
);
   localparam int unsigned IW = (out_depth > 1) ? $clog2(out_depth) : 1;
   localparam int unsigned CW = IW + 1;
   localparam logic [24:0]   RING_WORDS  = 25'(1) << buffer_aw;
   localparam logic [CW:0]   OUT_DEPTH_C = (CW + 1)'(out_depth);

   typedef enum logic [1:0] {IDLE, REQ_WR, REQ_RD} state_e;

   state_e                 state_q, state_d;
   logic                   last_wr_q, last_wr_d;
   logic                   avalid_q, avalid_d;
   logic                   awe_q, awe_d;
   logic [23:0]            aaddr_q, aaddr_d;
   logic [15:0]            adata_q, adata_d;

   logic                   hold_v_q;
   logic [15:0]            hold_data_q;
   logic [buffer_aw-1:0]   wr_ptr_q, rd_ptr_q;
   logic [24:0]            level_q;
   logic [CW-1:0]          inflight_q, occ_q;
   logic [IW-1:0]          head_q, tail_q;
   logic [15:0]            obuf_q [out_depth];

   logic wr_acc, rd_acc, s_acc, wr_elig, rd_elig, b_push, m_pop;

   assign wr_acc  = avalid_q & awe_q & aready;
   assign rd_acc  = avalid_q & ~awe_q & aready;
   assign s_ready = ~rst & (~hold_v_q | wr_acc);
   assign s_acc   = s_valid & s_ready;
   assign wr_elig = hold_v_q && (level_q < RING_WORDS);
   // Reserve output-buffer space before issuing so returned data always fits.
   assign rd_elig = (level_q != '0) &&
                    (({1'b0, inflight_q} + {1'b0, occ_q}) < OUT_DEPTH_C);
   // Strobes with nothing outstanding (e.g. left over from before a reset) are dropped.
   assign b_push  = bvalid && (inflight_q != '0);
   assign m_valid = (occ_q != '0);
   assign m_pop   = m_valid & m_ready;
   assign m_data  = obuf_q[head_q];

   assign avalid = avalid_q;
   assign awe    = awe_q;
   assign aaddr  = aaddr_q;
   assign adata  = adata_q;
   assign level  = level_q;
   assign empty  = (level_q == '0) && (occ_q == '0) && (inflight_q == '0);

   // Arbiter state register and registered a-channel
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
         avalid_q  <= 1'b0;
         awe_q     <= 1'b0;
         aaddr_q   <= '0;
         adata_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         avalid_q  <= avalid_d;
         awe_q     <= awe_d;
         aaddr_q   <= aaddr_d;
         adata_q   <= adata_d;
      end
   end

   // Round-robin between write and read when both are eligible
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      avalid_d  = avalid_q;
      awe_d     = awe_q;
      aaddr_d   = aaddr_q;
      adata_d   = adata_q;
      unique case (state_q)
         IDLE: begin
            if (wr_elig && (!rd_elig || !last_wr_q)) begin
               state_d  = REQ_WR;
               avalid_d = 1'b1;
               awe_d    = 1'b1;
               aaddr_d  = 24'(wr_ptr_q);
               adata_d  = hold_data_q;
            end else if (rd_elig) begin
               state_d  = REQ_RD;
               avalid_d = 1'b1;
               awe_d    = 1'b0;
               aaddr_d  = 24'(rd_ptr_q);
            end
         end
         REQ_WR, REQ_RD: begin
            if (aready) begin
               state_d   = IDLE;
               avalid_d  = 1'b0;
               last_wr_d = (state_q == REQ_WR);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Holding register, ring pointers, counters and output buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v_q    <= 1'b0;
         hold_data_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         inflight_q  <= '0;
         occ_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         for (int i = 0; i < int'(out_depth); i++) obuf_q[i] <= '0;
      end else begin
         if (s_acc) begin
            hold_v_q    <= 1'b1;
            hold_data_q <= s_data;
         end else if (wr_acc) begin
            hold_v_q <= 1'b0;
         end
         if (wr_acc) wr_ptr_q <= wr_ptr_q + buffer_aw'(1);
         if (rd_acc) rd_ptr_q <= rd_ptr_q + buffer_aw'(1);
         if (wr_acc && !rd_acc)      level_q <= level_q + 25'd1;
         else if (rd_acc && !wr_acc) level_q <= level_q - 25'd1;
         if (rd_acc && !b_push)      inflight_q <= inflight_q + CW'(1);
         else if (b_push && !rd_acc) inflight_q <= inflight_q - CW'(1);
         if (b_push && !m_pop)      occ_q <= occ_q + CW'(1);
         else if (m_pop && !b_push) occ_q <= occ_q - CW'(1);
         if (b_push) begin
            obuf_q[tail_q] <= bdata;
            tail_q         <= tail_q + IW'(1);
         end
         if (m_pop) head_q <= head_q + IW'(1);
      end
   end
endmodule

// File: tb/tb_sdram_ring_fifo.sv
// Directed/random bench for sdram_ring_fifo: an SDRAM controller model on the
// a/b channels and an in-order scoreboard of accepted samples.
module tb_sdram_ring_fifo;
   localparam int unsigned AW   = 4;
   localparam int unsigned OD   = 4;
   localparam int          RING = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        avalid, awe;
   logic [23:0] aaddr;
   logic [15:0] adata;
   logic        aready = 1'b0;
   logic [15:0] bdata = '0;
   logic        bvalid = 1'b0;
   logic [24:0] level;
   logic        empty;

   sdram_ring_fifo #(.buffer_aw(AW), .out_depth(OD)) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .avalid(avalid), .awe(awe), .aaddr(aaddr), .adata(adata), .aready(aready),
      .bdata(bdata), .bvalid(bvalid),
      .level(level), .empty(empty)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Controller model state and bench knobs
   typedef struct { logic [15:0] d; int due; } rd_t;
   rd_t         rq[$];
   logic [15:0] mem [RING];
   int          cyc = 0;
   int          lat = 2;
   bit          force_low = 0, rand_ready = 0, m_rand = 0, m_en = 1;

   // Reference: every accepted sample, in order, since the last reset
   logic [15:0] in_log[$];
   int  n_wr = 0, n_rd = 0, n_ret = 0, n_pop = 0, stale = 0;
   bit  rec = 0;
   bit  req_log[$];
   bit  prev_pend = 0;

   // Monitor: checks state, then records the handshakes of the coming edge
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk(64'(s_ready), 64'(0), "s_ready_in_rst");
         if (bvalid && rq.size() > 0) rq.delete(0);
         in_log.delete();
         n_wr = 0; n_rd = 0; n_ret = 0; n_pop = 0;
         stale = rq.size();
         prev_pend = 0;
      end else begin
         chk(64'(level), 64'(n_wr - n_rd), "level");
         chk(64'(empty), 64'(n_rd == n_wr && n_pop == n_rd), "empty");
         chk(64'(m_valid), 64'(n_ret > n_pop), "m_valid");
         chk(64'(n_rd - n_pop <= int'(OD)), 64'(1), "credit_bound");
         if (prev_pend) chk(64'(avalid), 64'(1), "avalid_held");
         if (s_valid && s_ready) in_log.push_back(s_data);
         if (avalid && aready) begin
            if (awe) begin
               chk(64'(aaddr), 64'(n_wr % RING), "wr_addr");
               chk(64'(in_log.size() > n_wr), 64'(1), "wr_has_sample");
               if (in_log.size() > n_wr) chk(64'(adata), 64'(in_log[n_wr]), "wr_data");
               mem[aaddr[3:0]] = adata;
               n_wr++;
            end else begin
               chk(64'(aaddr), 64'(n_rd % RING), "rd_addr");
               rq.push_back('{d: mem[aaddr[3:0]], due: cyc + lat});
               n_rd++;
            end
            if (rec) req_log.push_back(awe);
         end
         if (bvalid) begin
            if (rq.size() > 0) rq.delete(0);
            if (stale > 0) stale--;
            else n_ret++;
         end
         if (m_valid && m_ready) begin
            chk(64'(in_log.size() > n_pop), 64'(1), "pop_has_sample");
            if (in_log.size() > n_pop) chk(64'(m_data), 64'(in_log[n_pop]), "m_data");
            n_pop++;
         end
         prev_pend = avalid && !aready;
      end
   end

   // Controller/consumer drive, just after the active edge
   always @(posedge clk) begin
      #2;
      aready = (rst || force_low) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         bvalid = 1'b1;
         bdata  = rq[0].d;
      end else begin
         bvalid = 1'b0;
         bdata  = 16'($urandom);
      end
      m_ready = m_rand ? 1'($urandom_range(0, 1)) : m_en;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   task automatic push(input int n, input int base, input bit rnd);
      for (int i = 0; i < n; i++) begin
         int  b = 0;
         bit  done = 0;
         s_valid = 1'b1;
         s_data  = rnd ? 16'($urandom) : 16'(base + i);
         while (!done && b < 500) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
            b++;
         end
         chk(64'(done), 64'(1), "push_timeout");
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_pops(input int target, input int budget, input string tag);
      int b = 0;
      while (n_pop < target && b < budget) begin
         step(1);
         b++;
      end
      step(3);
      chk(64'(n_pop), 64'(target), tag);
   endtask

   initial begin
      for (int i = 0; i < RING; i++) mem[i] = '0;

      // Reset values, then five samples straight through
      do_reset();
      @(negedge clk);
      chk(64'(s_ready), 64'(1), "rst_s_ready");
      chk(64'(empty), 64'(1), "rst_empty");
      chk(64'(avalid), 64'(0), "rst_avalid");
      chk(64'({awe, aaddr, adata}), 64'(0), "rst_achan");
      chk(64'(level), 64'(0), "rst_level");
      chk(64'(m_valid), 64'(0), "rst_m_valid");
      step(1);
      push(5, 0, 0);
      wait_pops(5, 200, "basic_drain");
      @(negedge clk);
      chk(64'(empty), 64'(1), "basic_empty");
      step(1);

      // Fill the ring with the consumer stalled
      do_reset();
      m_en = 0;
      push(21, 0, 0);
      step(20);
      @(negedge clk);
      chk(64'(level), 64'(16), "full_level");
      chk(64'(s_ready), 64'(0), "full_s_ready");
      chk(64'(avalid), 64'(0), "full_idle");
      chk(64'(m_valid), 64'(1), "full_m_valid");
      step(1);
      m_en = 1;
      wait_pops(21, 400, "full_drain");
      @(negedge clk);
      chk(64'(s_ready), 64'(1), "full_s_ready_back");
      chk(64'(empty), 64'(1), "full_empty");
      step(1);

      // Backlog with both sides eligible: requests must alternate
      do_reset();
      m_en = 0;
      push(14, 0, 1);
      m_en = 1;
      push(6, 0, 1);
      req_log.delete();
      rec = 1;
      push(16, 0, 1);
      rec = 0;
      chk(64'(req_log.size() >= 12), 64'(1), "alt_count");
      if (req_log.size() >= 12)
         for (int i = 1; i < 12; i++) chk(64'(req_log[i]), 64'(!req_log[i-1]), "alternate");
      wait_pops(in_log.size(), 600, "alt_drain");

      // Stalled aready: request fields must stay put
      force_low = 1;
      push(1, 16'hA5C3, 0);
      begin
         int b = 0;
         @(negedge clk);
         while (!avalid && b < 50) begin
            @(negedge clk);
            b++;
         end
      end
      chk(64'(avalid), 64'(1), "stall_req_seen");
      repeat (5) begin
         chk(64'(avalid), 64'(1), "stall_avalid");
         chk(64'(awe), 64'(1), "stall_awe");
         chk(64'(aaddr), 64'(n_wr % RING), "stall_aaddr");
         chk(64'(adata), 64'(16'hA5C3), "stall_adata");
         @(negedge clk);
      end
      step(1);
      force_low = 0;
      wait_pops(in_log.size(), 200, "stall_drain");

      // Credit limit with slow reads and a stalled consumer
      do_reset();
      lat = 6;
      m_en = 0;
      push(10, 100, 0);
      step(60);
      @(negedge clk);
      chk(64'(level), 64'(6), "credit_level");
      chk(64'(m_valid), 64'(1), "credit_m_valid");
      repeat (10) begin
         chk(64'(avalid && !awe), 64'(0), "credit_no_read");
         @(negedge clk);
      end
      step(1);
      m_en = 1;
      wait_pops(10, 300, "credit_drain");

      // Random streaming across two ring wraps
      do_reset();
      lat = 3;
      rand_ready = 1;
      m_rand = 1;
      push(40, 0, 1);
      wait_pops(40, 2000, "wrap_drain");
      @(negedge clk);
      chk(64'(n_wr), 64'(40), "wrap_writes");
      chk(64'(empty), 64'(1), "wrap_empty");
      step(1);
      rand_ready = 0;
      m_rand = 0;

      // Reset with reads outstanding; late returns must be ignored
      do_reset();
      lat = 12;
      m_en = 0;
      push(3, 50, 0);
      begin
         int b = 0;
         while (n_rd < 2 && b < 200) begin
            step(1);
            b++;
         end
      end
      chk(64'(n_rd >= 2), 64'(1), "mid_reads_issued");
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      chk(64'(level), 64'(0), "mid_rst_level");
      chk(64'(m_valid), 64'(0), "mid_rst_m_valid");
      chk(64'(avalid), 64'(0), "mid_rst_avalid");
      chk(64'(empty), 64'(1), "mid_rst_empty");
      chk(64'(stale > 0), 64'(1), "mid_late_pending");
      repeat (20) begin
         @(negedge clk);
         chk(64'(m_valid), 64'(0), "late_bvalid_ignored");
      end
      chk(64'(empty), 64'(1), "final_empty");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
